// File: rtl/fc_stream_layer_if.sv
// Activation-in / result-out stream bundle for fc_stream_layer.
// N is the sample/result width, IW the neuron-index width.
interface fc_stream_layer_if #(
   parameter int N  = 16,
   parameter int IW = 1
);
   logic [N-1:0]  din;
   logic          din_valid;
   logic          din_ready;
   logic [N-1:0]  dout;
   logic          dout_valid;
   logic [IW-1:0] dout_idx;
   logic          dout_last;
   logic          drop_err;

   modport master (
      output din, din_valid,
      input  din_ready, dout, dout_valid, dout_idx, dout_last, drop_err
   );

   modport slave (
      input  din, din_valid,
      output din_ready, dout, dout_valid, dout_idx, dout_last, drop_err
   );
endinterface

// File: rtl/fc_stream_layer.sv
// Streaming dense layer: MACs each incoming (N,Q) sample against all neurons,
// then emits OUT_LEN biased, rescaled, saturated results one per cycle.
module fc_stream_layer #(
   parameter int IN_LEN  = 16,
   parameter int OUT_LEN = 2,
   parameter int N       = 16,
   parameter int Q       = 12
) (
   input  logic                        clk,
   input  logic                        global_rst,
   input  logic                        ce,
   input  logic [IN_LEN*OUT_LEN*N-1:0] weight,
   input  logic [OUT_LEN*N-1:0]        bias,
   fc_stream_layer_if.slave            stream
);
   localparam int CW = (IN_LEN  > 1) ? $clog2(IN_LEN)  : 1;
   localparam int IW = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;
   localparam int AW = 2*N + $clog2(IN_LEN) + 1;

   localparam logic [CW-1:0] CNT_LAST  = CW'(IN_LEN - 1);
   localparam logic [IW-1:0] OIDX_LAST = IW'(OUT_LEN - 1);

   localparam logic signed [AW:0] SAT_MAX = {{(AW+2-N){1'b0}}, {(N-1){1'b1}}};
   localparam logic signed [AW:0] SAT_MIN = {{(AW+2-N){1'b1}}, {(N-1){1'b0}}};

   typedef enum logic {ACCUM, EMIT} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [CW-1:0]         r_cnt;
   logic [CW-1:0]         w_cnt_nxt;
   logic [IW-1:0]         r_oidx;
   logic [IW-1:0]         w_oidx_nxt;
   logic signed [AW-1:0]  r_acc [OUT_LEN];
   logic                  r_drop_err;
   logic                  w_accept;
   logic                  w_clear;
   logic                  w_drop;

   logic signed [2*N-1:0] w_prod [OUT_LEN];
   logic signed [N-1:0]   w_wsel [OUT_LEN];
   logic signed [N-1:0]   w_bsel;
   logic signed [AW:0]    w_sum;
   logic signed [AW:0]    w_shr;
   logic [N-1:0]          w_sat;

   always_ff @(posedge clk or negedge global_rst) begin
      if (!global_rst) begin
         r_state <= ACCUM;
         r_cnt   <= '0;
         r_oidx  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_oidx  <= w_oidx_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_oidx_nxt  = r_oidx;
      w_accept    = 1'b0;
      w_clear     = 1'b0;
      w_drop      = 1'b0;
      if (ce) begin
         unique case (r_state)
            ACCUM: begin
               if (stream.din_valid) begin
                  w_accept = 1'b1;
                  if (r_cnt == CNT_LAST) begin
                     w_cnt_nxt   = '0;
                     w_oidx_nxt  = '0;
                     w_state_nxt = EMIT;
                  end else begin
                     w_cnt_nxt = r_cnt + CW'(1);
                  end
               end
            end
            EMIT: begin
               w_drop = stream.din_valid;
               if (r_oidx == OIDX_LAST) begin
                  w_oidx_nxt  = '0;
                  w_clear     = 1'b1;
                  w_state_nxt = ACCUM;
               end else begin
                  w_oidx_nxt = r_oidx + IW'(1);
               end
            end
            default: w_state_nxt = ACCUM;
         endcase
      end
   end

   // Weight column for the current sample position, one per neuron.
   always_comb begin
      for (int unsigned o = 0; o < OUT_LEN; o++) begin
         w_wsel[o] = weight[(int'(o)*IN_LEN + int'(r_cnt))*N +: N];
         w_prod[o] = $signed(stream.din) * w_wsel[o];
      end
   end

   always_ff @(posedge clk or negedge global_rst) begin
      if (!global_rst) begin
         for (int unsigned o = 0; o < OUT_LEN; o++) r_acc[o] <= '0;
      end else if (w_clear) begin
         for (int unsigned o = 0; o < OUT_LEN; o++) r_acc[o] <= '0;
      end else if (w_accept) begin
         for (int unsigned o = 0; o < OUT_LEN; o++)
            r_acc[o] <= r_acc[o] + {{(AW-2*N){w_prod[o][2*N-1]}}, w_prod[o]};
      end
   end

   always_ff @(posedge clk or negedge global_rst) begin
      if (!global_rst)  r_drop_err <= 1'b0;
      else if (w_drop)  r_drop_err <= 1'b1;
   end

   // Bias is aligned to the 2Q product scale before the floor shift back to Q.
   always_comb begin
      w_bsel = bias[int'(r_oidx)*N +: N];
      w_sum  = {r_acc[r_oidx][AW-1], r_acc[r_oidx]}
             + ({{(AW+1-N){w_bsel[N-1]}}, w_bsel} <<< Q);
      w_shr  = w_sum >>> Q;
      if (w_shr > SAT_MAX)      w_sat = SAT_MAX[N-1:0];
      else if (w_shr < SAT_MIN) w_sat = SAT_MIN[N-1:0];
      else                      w_sat = w_shr[N-1:0];
   end

   assign stream.din_ready  = (r_state == ACCUM);
   assign stream.dout_valid = (r_state == EMIT);
   assign stream.dout_idx   = r_oidx;
   assign stream.dout_last  = (r_state == EMIT) && (r_oidx == OIDX_LAST);
   assign stream.dout       = (r_state == EMIT) ? w_sat : '0;
   assign stream.drop_err   = r_drop_err;
endmodule

// File: tb/tb_fc_stream_layer.sv
// Directed bench for fc_stream_layer at IN_LEN=4, OUT_LEN=2, N=16, Q=12.
module tb_fc_stream_layer;
   logic         clk = 1'b0;
   logic         global_rst = 1'b0;
   logic         ce = 1'b1;
   logic [127:0] weight = '0;
   logic [31:0]  bias = '0;
   int           vectors = 0;
   int           miscompares = 0;

   fc_stream_layer_if #(.N(16), .IW(1)) bus ();

   fc_stream_layer #(.IN_LEN(4), .OUT_LEN(2), .N(16), .Q(12)) dut (
      .clk        (clk),
      .global_rst (global_rst),
      .ce         (ce),
      .weight     (weight),
      .bias       (bias),
      .stream     (bus)
   );

   always #5 clk = ~clk;

   task automatic set_weights(input logic [15:0] w0, input logic [15:0] w1);
      for (int j = 0; j < 4; j++) begin
         weight[j*16 +: 16]     = w0;
         weight[(4+j)*16 +: 16] = w1;
      end
   endtask

   // Drives four samples (sample j in d[j*16 +: 16]); optional idle cycle between them.
   task automatic send_frame(input logic [63:0] d, input bit gaps);
      for (int j = 0; j < 4; j++) begin
         bus.din = d[j*16 +: 16];
         bus.din_valid = 1'b1;
         @(posedge clk); #1;
         bus.din_valid = 1'b0;
         bus.din = '0;
         if (gaps && j < 3) begin @(posedge clk); #1; end
      end
   endtask

   task automatic test_reset;
      vectors++; if (bus.din_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got=%b exp=1", bus.din_ready); end
      vectors++; if (bus.dout_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b exp=0", bus.dout_valid); end
      vectors++; if (bus.dout !== 16'h0000) begin miscompares++; $display("FAIL reset_dout got=%h exp=0000", bus.dout); end
      vectors++; if (bus.drop_err !== 1'b0) begin miscompares++; $display("FAIL reset_drop got=%b exp=0", bus.drop_err); end
      #7 global_rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic_mac;
      set_weights(16'h1000, 16'hF800);
      bias = '0;
      for (int j = 0; j < 4; j++) begin
         bus.din = 16'h1000; bus.din_valid = 1'b1;
         @(posedge clk); #1;
         if (j == 2) begin
            vectors++; if (bus.dout_valid !== 1'b0) begin miscompares++; $display("FAIL basic_early_valid got=%b exp=0", bus.dout_valid); end
         end
      end
      bus.din_valid = 1'b0;
      vectors++; if (bus.dout_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid0 got=%b exp=1", bus.dout_valid); end
      vectors++; if (bus.din_ready !== 1'b0) begin miscompares++; $display("FAIL basic_ready got=%b exp=0", bus.din_ready); end
      vectors++; if (bus.dout !== 16'h4000 || bus.dout_idx !== 1'b0 || bus.dout_last !== 1'b0) begin miscompares++; $display("FAIL basic_out0 got=%h/%b/%b exp=4000/0/0", bus.dout, bus.dout_idx, bus.dout_last); end
      @(posedge clk); #1;
      vectors++; if (bus.dout !== 16'hE000 || bus.dout_idx !== 1'b1 || bus.dout_last !== 1'b1) begin miscompares++; $display("FAIL basic_out1 got=%h/%b/%b exp=e000/1/1", bus.dout, bus.dout_idx, bus.dout_last); end
      @(posedge clk); #1;
      vectors++; if (bus.dout_valid !== 1'b0 || bus.dout !== 16'h0000 || bus.din_ready !== 1'b1) begin miscompares++; $display("FAIL basic_end got=%b/%h/%b exp=0/0000/1", bus.dout_valid, bus.dout, bus.din_ready); end
   endtask

   task automatic test_saturation_bias;
      set_weights(16'h7FFF, 16'h7FFF);
      send_frame({4{16'h7FFF}}, 1'b0);
      vectors++; if (bus.dout !== 16'h7FFF) begin miscompares++; $display("FAIL sat_pos0 got=%h exp=7fff", bus.dout); end
      @(posedge clk); #1;
      vectors++; if (bus.dout !== 16'h7FFF) begin miscompares++; $display("FAIL sat_pos1 got=%h exp=7fff", bus.dout); end
      @(posedge clk); #1;
      set_weights(16'h7FFF, 16'h8000);
      send_frame({4{16'h7FFF}}, 1'b0);
      @(posedge clk); #1;
      vectors++; if (bus.dout !== 16'h8000 || bus.dout_last !== 1'b1) begin miscompares++; $display("FAIL sat_neg got=%h/%b exp=8000/1", bus.dout, bus.dout_last); end
      @(posedge clk); #1;
      bias = {16'h0000, 16'h0800};
      send_frame(64'h0, 1'b0);
      vectors++; if (bus.dout !== 16'h0800) begin miscompares++; $display("FAIL bias0 got=%h exp=0800", bus.dout); end
      @(posedge clk); #1;
      vectors++; if (bus.dout !== 16'h0000) begin miscompares++; $display("FAIL bias1 got=%h exp=0000", bus.dout); end
      @(posedge clk); #1;
      bias = '0;
   endtask

   task automatic test_floor_rounding;
      weight = '0;
      weight[15:0]   = 16'h0001;
      weight[79:64]  = 16'hFFFF;
      send_frame(64'h0000_0000_0000_0001, 1'b0);
      vectors++; if (bus.dout !== 16'h0000) begin miscompares++; $display("FAIL floor_pos got=%h exp=0000", bus.dout); end
      @(posedge clk); #1;
      vectors++; if (bus.dout !== 16'hFFFF) begin miscompares++; $display("FAIL floor_neg got=%h exp=ffff", bus.dout); end
      @(posedge clk); #1;
   endtask

   task automatic test_gaps_ce;
      set_weights(16'h1000, 16'hF800);
      send_frame({4{16'h1000}}, 1'b1);
      vectors++; if (bus.dout !== 16'h4000 || bus.dout_valid !== 1'b1) begin miscompares++; $display("FAIL gap_out0 got=%h/%b exp=4000/1", bus.dout, bus.dout_valid); end
      ce = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         vectors++; if (bus.dout !== 16'h4000 || bus.dout_idx !== 1'b0 || bus.dout_valid !== 1'b1) begin miscompares++; $display("FAIL ce_hold%0d got=%h/%b/%b exp=4000/0/1", k, bus.dout, bus.dout_idx, bus.dout_valid); end
      end
      ce = 1'b1;
      @(posedge clk); #1;
      vectors++; if (bus.dout !== 16'hE000 || bus.dout_idx !== 1'b1 || bus.dout_last !== 1'b1) begin miscompares++; $display("FAIL gap_out1 got=%h/%b/%b exp=e000/1/1", bus.dout, bus.dout_idx, bus.dout_last); end
      @(posedge clk); #1;
      vectors++; if (bus.dout_valid !== 1'b0) begin miscompares++; $display("FAIL gap_end got=%b exp=0", bus.dout_valid); end
   endtask

   task automatic test_drop;
      send_frame({4{16'h1000}}, 1'b0);
      bus.din = 16'h7FFF; bus.din_valid = 1'b1;
      @(posedge clk); #1;
      vectors++; if (bus.drop_err !== 1'b1) begin miscompares++; $display("FAIL drop_set got=%b exp=1", bus.drop_err); end
      @(posedge clk); #1;
      bus.din_valid = 1'b0; bus.din = '0;
      send_frame({4{16'h1000}}, 1'b0);
      vectors++; if (bus.dout !== 16'h4000) begin miscompares++; $display("FAIL drop_next0 got=%h exp=4000", bus.dout); end
      @(posedge clk); #1;
      vectors++; if (bus.dout !== 16'hE000) begin miscompares++; $display("FAIL drop_next1 got=%h exp=e000", bus.dout); end
      vectors++; if (bus.drop_err !== 1'b1) begin miscompares++; $display("FAIL drop_sticky got=%b exp=1", bus.drop_err); end
      @(posedge clk); #1;
   endtask

   task automatic test_async_reset;
      for (int j = 0; j < 2; j++) begin
         bus.din = 16'h7FFF; bus.din_valid = 1'b1;
         @(posedge clk); #1;
      end
      bus.din_valid = 1'b0; bus.din = '0;
      #2 global_rst = 1'b0;
      #1;
      vectors++; if (bus.din_ready !== 1'b1 || bus.dout_valid !== 1'b0 || bus.dout !== 16'h0000) begin miscompares++; $display("FAIL arst_out got=%b/%b/%h exp=1/0/0000", bus.din_ready, bus.dout_valid, bus.dout); end
      vectors++; if (bus.dout_idx !== 1'b0 || bus.dout_last !== 1'b0 || bus.drop_err !== 1'b0) begin miscompares++; $display("FAIL arst_flags got=%b/%b/%b exp=0/0/0", bus.dout_idx, bus.dout_last, bus.drop_err); end
      #2 global_rst = 1'b1;
      @(posedge clk); #1;
      send_frame({4{16'h1000}}, 1'b0);
      vectors++; if (bus.dout !== 16'h4000 || bus.dout_idx !== 1'b0) begin miscompares++; $display("FAIL arst_out0 got=%h/%b exp=4000/0", bus.dout, bus.dout_idx); end
      @(posedge clk); #1;
      vectors++; if (bus.dout !== 16'hE000 || bus.dout_last !== 1'b1) begin miscompares++; $display("FAIL arst_out1 got=%h/%b exp=e000/1", bus.dout, bus.dout_last); end
      @(posedge clk); #1;
   endtask

   initial begin
      bus.din = '0;
      bus.din_valid = 1'b0;
      #2;
      test_reset;
      test_basic_mac;
      test_saturation_bias;
      test_floor_rounding;
      test_gaps_ce;
      test_drop;
      test_async_reset;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/fc_stream_layer.md
# fc_stream_layer

Streaming fully-connected (dense) layer that sits directly downstream of the convolution/ReLU/pooling block. It consumes the pooled activation stream one fixed-point sample per cycle and multiply-accumulates each sample against all output neurons in parallel. After a full frame of `IN_LEN` samples it emits `OUT_LEN` biased, rescaled and saturated results, one per cycle, then rearms for the next frame.

## Interface
- `IN_LEN`, 16: samples per frame, equal to (pooled map side)²; minimum 2.
- `OUT_LEN`, 2: output neurons; minimum 1.
- `N`, 16: data, weight and bias width in two's complement.
- `Q`, 12: fractional bits of the (N,Q) format.
- `clk` input 1: clock; all state changes on the rising edge.
- `global_rst` input 1: asynchronous, active-low reset.
- `ce` input 1: clock enable; when low, all state holds and no sample is accepted.
- `din` input N: pooled activation in (N,Q).
- `din_valid` input 1: `din` is valid this cycle.
- `din_ready` output 1: high in ACCUM state; low in EMIT state.
- `weight` input IN_LEN\*OUT_LEN\*N: flat weight array. The weight for neuron o and sample j is `weight[(o*IN_LEN+j)*N +: N]`. Must be static during a frame.
- `bias` input OUT_LEN\*N: the bias for neuron o is `bias[o*N +: N]`, in (N,Q).
- `dout` output N: result for neuron `dout_idx`, in (N,Q).
- `dout_valid` output 1: `dout` is valid.
- `dout_idx` output clog2(OUT_LEN) (min 1): neuron index of `dout`.
- `dout_last` output 1: high together with the result for the last neuron (`OUT_LEN-1`).
- `drop_err` output 1: sticky flag; set when a sample arrives while `din_ready` is low.

## Operation
- **States:**
  - ACCUM: the reset state.
  - EMIT: entered from ACCUM on acceptance of the IN_LEN-th sample.
- **Registers:** sample counter `cnt` (0..IN_LEN-1), output index `oidx` (0..OUT_LEN-1), and OUT_LEN signed accumulators of width `AW = 2N + clog2(IN_LEN) + 1`.
- **Acceptance:** a sample is accepted when `ce & din_valid & state==ACCUM`.
  - Each accumulator o adds the full-precision product `din * w[o][cnt]` (2N bits, sign-extended).
  - `cnt` increments.
  - When `cnt==IN_LEN-1` on acceptance: `cnt` goes to 0, state goes to EMIT, `oidx` goes to 0.
- **EMIT:** on each `ce` cycle, `oidx` increments.
  - When `oidx==OUT_LEN-1`: state goes to ACCUM and all accumulators clear to 0 on that same edge.
  - The EMIT state lasts exactly OUT_LEN `ce` cycles.
- **Result arithmetic:** combinational from registers.
  - `s = acc[oidx] + (sign_ext(bias[oidx]) << Q)`.
  - `r = s >>> Q` (arithmetic shift, floor rounding).
  - Saturate `r` to [-2^(N-1), 2^(N-1)-1]; the saturated value drives `dout`.
- **Output drive:**
  - `dout_valid = (state==EMIT)`.
  - `dout_idx = oidx`.
  - `dout_last = dout_valid & (oidx==OUT_LEN-1)`.
  - `dout` is 0 whenever `dout_valid` is low.
- **Drop errors:** `din_valid & ce & state==EMIT` sets `drop_err`. The sample is discarded and does not count toward the next frame. Only reset clears `drop_err`.
- **Reset values** (asynchronous, while `global_rst` is low):
  - State is ACCUM; `cnt`, `oidx` and all accumulators are 0.
  - `din_ready`=1; `dout_valid`=0; `dout`=0; `dout_idx`=0; `dout_last`=0; `drop_err`=0.
- **Reset mid-frame:** any partial accumulation or in-progress EMIT is abandoned. The first sample accepted after reset release is sample 0 of a new frame.
- **Accumulator overflow:** impossible by construction of `AW`; saturation is applied only at the output.

## Timing
- Throughput while accumulating: one sample per cycle, with no bubbles.
- Latency: `dout_valid` rises in the cycle immediately after the edge that accepts sample IN_LEN-1, and stays high for OUT_LEN consecutive `ce` cycles.
- Frame gap: the first sample of the next frame can be accepted in the cycle after `dout_last`. The minimum frame period is IN_LEN+OUT_LEN cycles.
- `ce` low during EMIT stretches the output phase. `dout`, `dout_valid` and `dout_idx` hold their values.
- Gaps in `din_valid` during ACCUM are allowed; accumulation simply pauses.
- No downstream backpressure: the consumer must capture each result in the cycle it is presented.

## Test plan
All scenarios use IN_LEN=4, OUT_LEN=2, N=16, Q=12 and bias 0 unless noted.
- **Basic MAC:** all `w[0]` = 0x1000 (1.0), all `w[1]` = 0xF800 (-0.5); 4 back-to-back samples of 0x1000. Required: `dout` = 0x4000 with idx 0, then 0xE000 with idx 1 and `dout_last`=1. `dout_valid` rises 1 cycle after the 4th accept edge.
- **Saturation and bias:**
  - Inputs and weights all 0x7FFF → 0x7FFF.
  - Inputs 0x7FFF with `w[1]` = 0x8000 → 0x8000.
  - Zero inputs with `bias[0]` = 0x0800 → `dout[0]` = 0x0800.
- **Floor rounding:** input 0x0001 on sample 0, all other inputs 0. With `w[0][0]` = 0x0001 → 0x0000. With `w[1][0]` = 0xFFFF → 0xFFFF.
- **Gaps and ce:** `din_valid` toggled 1-0-1-0 across the frame, and `ce` held low for 3 cycles during EMIT. Required: same results as the basic MAC test; each result is held through the `ce`-low cycles; no extra or missing `dout_valid` cycles.
- **Drop:** `din_valid` driven high during both EMIT cycles. Required: `drop_err` goes to 1 and stays at 1. The next frame's 4 samples give the correct results, uncontaminated by the dropped samples.
- **Async reset:** `global_rst` pulsed low after 2 accepted samples, asynchronously to `clk`. Required: all outputs go to their reset values immediately. A following full frame of 4 samples yields exactly the basic MAC results.
